mcu_cmd_ctrl: RTL and testbench

Command sequencer for the MCU SPI link. Consumes the byte strobe and byte value from mcu_spi (kbd_activate / mcu_dout) plus the raw slave-select, and parses each SS-low frame into commands. It routes keyboard report bytes into a buffered stream, performs config register reads and writes, and selects the reply byte fed back to mcu_spi's mcu_hid_din.

---
 rtl/mcu_cmd_pkg.sv | 42 ++++
 rtl/mcu_cmd_fifo.sv | 63 ++++++
 rtl/mcu_cmd_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_mcu_cmd_ctrl.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mcu_cmd_pkg.sv
// Shared definitions for the MCU SPI command sequencer: opcodes, FSM
// state encoding and the layout of the STATUS reply byte.
package mcu_cmd_pkg;

    // Command opcodes carried in the first byte of every SS-low frame.
    localparam logic [7:0] OP_NOP  = 8'h00;
    localparam logic [7:0] OP_KBD  = 8'h01;
    localparam logic [7:0] OP_STAT = 8'h02;
    localparam logic [7:0] OP_CFGW = 8'h03;
    localparam logic [7:0] OP_CFGR = 8'h04;

    // Frame parser states; the FSM only moves on a received byte or frame end.
    typedef enum logic [2:0] {
        S_IDLE,
        S_KBD_LEN,
        S_KBD_DATA,
        S_CFGW_ADDR,
        S_CFGW_DATA,
        S_CFGR_ADDR,
        S_STAT,
        S_DISCARD
    } state_t;

    // STATUS byte layout: {overflow, badcmd, 2'b00, level[3:0]}.
    localparam int          STAT_OVF_BIT = 7;
    localparam int          STAT_BAD_BIT = 6;
    localparam int          STAT_LVL_LSB = 0;
    localparam int          STAT_LVL_W   = 4;
    localparam int unsigned LEVEL_SAT    = 15;

    // Assemble the STATUS reply; the FIFO level saturates so deep FIFOs still fit in 4 bits.
    function automatic logic [7:0] status_byte(input logic ovf, input logic bad,
                                               input int unsigned level);
        logic [7:0] s;
        s = 8'h00;
        s[STAT_OVF_BIT] = ovf;
        s[STAT_BAD_BIT] = bad;
        s[STAT_LVL_LSB +: STAT_LVL_W] = (level > LEVEL_SAT) ? 4'(LEVEL_SAT) : 4'(level);
        return s;
    endfunction

endpackage

// File: rtl/mcu_cmd_fifo.sv
// Synchronous first-word-fall-through FIFO for the keyboard report stream.
// The head entry is visible on pop_data whenever the FIFO is not empty.
module mcu_cmd_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    output logic                   full,
    input  logic                   pop,
    output logic [WIDTH-1:0]       pop_data,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign empty = (count == '0);
    assign full  = (count == DEPTH_CNT);
    assign level = count;

    assign do_pop = pop && !empty;
    // A pop in the same cycle frees the slot first, so a full FIFO still takes the push.
    assign do_push = push && (!full || do_pop);

    // Present zero when empty so stale storage never shows on the stream after reset.
    assign pop_data = empty ? '0 : mem[rd_ptr];

    // Storage write port.
    // NOTE: the array is intentionally not reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    // Pointer and occupancy tracking.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/mcu_cmd_ctrl.sv
// MCU SPI command sequencer. Parses each SS-low frame of received bytes into
// keyboard reports, config reads/writes and status queries, and chooses the
// reply byte handed back to the SPI shifter.
module mcu_cmd_ctrl
    import mcu_cmd_pkg::*;
#(
    parameter int         FIFO_DEPTH  = 8,
    parameter int         MAX_PAYLOAD = 6,
    parameter logic [7:0] VERSION     = 8'h01
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       spi_ss,
    input  logic       rx_valid,
    input  logic [7:0] rx_byte,
    output logic [7:0] tx_byte,
    output logic [7:0] kbd_data,
    output logic       kbd_last,
    output logic       kbd_valid,
    input  logic       kbd_ready,
    output logic       cfg_we,
    output logic [3:0] cfg_addr,
    output logic [7:0] cfg_wdata,
    input  logic [7:0] cfg_rdata,
    input  logic [7:0] led_state,
    output logic       err_overflow,
    output logic       err_badcmd,
    output logic [7:0] frame_count
);
    localparam int         LW      = $clog2(FIFO_DEPTH) + 1;
    localparam int         RW      = $clog2(MAX_PAYLOAD + 1);
    localparam logic [7:0] MAX_LEN = 8'(MAX_PAYLOAD);

    state_t        state;
    logic [RW-1:0] remaining;
    logic [1:0]    stat_step;
    logic          rx_seen;
    logic          cfgr_pending;

    logic ss_meta;
    logic ss_sync;
    logic ss_sync_d;
    logic frame_end;

    logic          push_req;
    logic [8:0]    push_entry;
    logic [8:0]    head_entry;
    logic          pop_req;
    logic          fifo_full;
    logic          fifo_empty;
    logic [LW-1:0] fifo_level;
    logic          ovf_event;

    // Bring the raw slave select into the clk domain; idle (high) out of reset
    // so releasing reset never looks like an end of frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ss_meta   <= 1'b1;
            ss_sync   <= 1'b1;
            ss_sync_d <= 1'b1;
        end else begin
            ss_meta   <= spi_ss;
            ss_sync   <= ss_meta;
            ss_sync_d <= ss_sync;
        end
    end

    assign frame_end = ss_sync && !ss_sync_d;

    // Keyboard bytes are pushed straight from the receive strobe; a byte that
    // coincides with frame end is dropped along with the rest of the frame.
    assign push_req   = rx_valid && !frame_end && (state == S_KBD_DATA);
    assign push_entry = {(remaining == RW'(1)), rx_byte};
    assign pop_req    = kbd_valid && kbd_ready;
    assign ovf_event  = push_req && fifo_full && !pop_req;

    mcu_cmd_fifo #(
        .WIDTH (9),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_req),
        .push_data (push_entry),
        .full      (fifo_full),
        .pop       (pop_req),
        .pop_data  (head_entry),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    assign kbd_valid = !fifo_empty;
    assign kbd_last  = head_entry[8];
    assign kbd_data  = head_entry[7:0];

    // Frame parser, reply byte, config strobes, error flags and frame counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= S_IDLE;
            remaining    <= '0;
            stat_step    <= '0;
            rx_seen      <= 1'b0;
            cfgr_pending <= 1'b0;
            tx_byte      <= 8'h00;
            cfg_we       <= 1'b0;
            cfg_addr     <= 4'h0;
            cfg_wdata    <= 8'h00;
            err_overflow <= 1'b0;
            err_badcmd   <= 1'b0;
            frame_count  <= 8'h00;
        end else begin
            cfg_we       <= 1'b0;
            cfgr_pending <= 1'b0;

            if (frame_end) begin
                state   <= S_IDLE;
                tx_byte <= 8'h00;
                rx_seen <= 1'b0;
                if (rx_seen) frame_count <= frame_count + 8'd1;
                // Frames that stop before their command is complete are flagged.
                if (state inside {S_KBD_LEN, S_KBD_DATA, S_CFGW_ADDR, S_CFGW_DATA, S_CFGR_ADDR})
                    err_badcmd <= 1'b1;
            end else begin
                // Config read data follows the address by one clk (cfg_rdata is combinational).
                if (cfgr_pending) tx_byte <= cfg_rdata;

                if (rx_valid) begin
                    rx_seen <= 1'b1;
                    case (state)
                        S_IDLE: begin
                            case (rx_byte)
                                OP_NOP:  state <= S_IDLE;
                                OP_KBD:  state <= S_KBD_LEN;
                                OP_CFGW: state <= S_CFGW_ADDR;
                                OP_CFGR: state <= S_CFGR_ADDR;
                                OP_STAT: begin
                                    state        <= S_STAT;
                                    stat_step    <= '0;
                                    tx_byte      <= status_byte(err_overflow, err_badcmd,
                                                                32'(fifo_level));
                                    err_overflow <= 1'b0;
                                    err_badcmd   <= 1'b0;
                                end
                                default: begin
                                    state      <= S_DISCARD;
                                    err_badcmd <= 1'b1;
                                end
                            endcase
                        end
                        S_KBD_LEN: begin
                            if (rx_byte != 8'h00 && rx_byte <= MAX_LEN) begin
                                remaining <= rx_byte[RW-1:0];
                                state     <= S_KBD_DATA;
                            end else begin
                                err_badcmd <= 1'b1;
                                state      <= S_DISCARD;
                            end
                        end
                        S_KBD_DATA: begin
                            remaining <= remaining - RW'(1);
                            if (remaining == RW'(1)) state <= S_DISCARD;
                        end
                        S_CFGW_ADDR: begin
                            cfg_addr <= rx_byte[3:0];
                            state    <= S_CFGW_DATA;
                        end
                        S_CFGW_DATA: begin
                            cfg_wdata <= rx_byte;
                            cfg_we    <= 1'b1;
                            state     <= S_DISCARD;
                        end
                        S_CFGR_ADDR: begin
                            cfg_addr     <= rx_byte[3:0];
                            cfgr_pending <= 1'b1;
                            state        <= S_DISCARD;
                        end
                        S_STAT: begin
                            case (stat_step)
                                2'd0:    tx_byte <= led_state;
                                2'd1:    tx_byte <= VERSION;
                                default: tx_byte <= 8'h00;
                            endcase
                            if (stat_step != 2'd2) stat_step <= stat_step + 2'd1;
                        end
                        S_DISCARD: ;
                    endcase
                end
            end

            // NOTE: placed last so this non-blocking write overrides the STATUS clear in the same cycle.
            if (ovf_event) err_overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mcu_cmd_ctrl.sv
// Scoreboard bench for mcu_cmd_ctrl: expected keyboard entries are queued
// as bytes are sent and compared as the DUT hands them out.
module tb_mcu_cmd_ctrl;
    localparam int         FIFO_DEPTH = 8;
    localparam logic [7:0] VERSION    = 8'h01;

    logic       clk = 1'b0;
    logic       reset;
    logic       spi_ss;
    logic       rx_valid;
    logic [7:0] rx_byte;
    logic [7:0] tx_byte;
    logic [7:0] kbd_data;
    logic       kbd_last;
    logic       kbd_valid;
    logic       kbd_ready;
    logic       cfg_we;
    logic [3:0] cfg_addr;
    logic [7:0] cfg_wdata;
    logic [7:0] cfg_rdata;
    logic [7:0] led_state;
    logic       err_overflow;
    logic       err_badcmd;
    logic [7:0] frame_count;

    always #5 clk = ~clk;

    // Config register file stand-in: combinational read data.
    assign cfg_rdata = (cfg_addr == 4'h7) ? 8'h3C : {4'hE, cfg_addr};

    mcu_cmd_ctrl #(
        .FIFO_DEPTH  (FIFO_DEPTH),
        .MAX_PAYLOAD (6),
        .VERSION     (VERSION)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .spi_ss       (spi_ss),
        .rx_valid     (rx_valid),
        .rx_byte      (rx_byte),
        .tx_byte      (tx_byte),
        .kbd_data     (kbd_data),
        .kbd_last     (kbd_last),
        .kbd_valid    (kbd_valid),
        .kbd_ready    (kbd_ready),
        .cfg_we       (cfg_we),
        .cfg_addr     (cfg_addr),
        .cfg_wdata    (cfg_wdata),
        .cfg_rdata    (cfg_rdata),
        .led_state    (led_state),
        .err_overflow (err_overflow),
        .err_badcmd   (err_badcmd),
        .frame_count  (frame_count)
    );

    logic [40:0] all_outs;
    assign all_outs = {tx_byte, kbd_data, kbd_last, kbd_valid, cfg_we, cfg_addr,
                       cfg_wdata, err_overflow, err_badcmd, frame_count};

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state.
    logic [8:0] exp_q[$];
    logic       m_ovf = 1'b0;
    logic       m_bad = 1'b0;
    logic [7:0] m_frames = 8'h00;
    bit         frame_has_rx = 1'b0;

    int         we_count = 0;
    logic [3:0] we_addr;
    logic [7:0] we_data;

    // Stream monitor: a handshake seen on the falling edge completes on the next rising edge.
    always @(negedge clk) begin
        logic [8:0] e;
        if (reset && cfg_we) begin
            we_count++;
            we_addr = cfg_addr;
            we_data = cfg_wdata;
        end
        if (reset && kbd_valid && kbd_ready) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL kbd_unexpected: got last=%0b data=%h, required no entry", kbd_last, kbd_data);
            end else begin
                e = exp_q.pop_front();
                if ({kbd_last, kbd_data} !== e) begin
                    miscompares++;
                    $display("FAIL kbd_stream: got last=%0b data=%h, required last=%0b data=%h",
                             kbd_last, kbd_data, e[8], e[7:0]);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #2;
        rx_valid = 1'b1;
        rx_byte  = b;
        frame_has_rx = 1'b1;
        @(posedge clk); #2;
        rx_valid = 1'b0;
    endtask

    // Send a keyboard data byte and record what the FIFO should hold.
    task automatic kbd_byte(input logic [7:0] b, input logic last);
        if (exp_q.size() >= FIFO_DEPTH && !kbd_ready) m_ovf = 1'b1;
        else exp_q.push_back({last, b});
        send_byte(b);
    endtask

    task automatic ss_low();
        @(posedge clk); #2;
        spi_ss = 1'b0;
        frame_has_rx = 1'b0;
    endtask

    task automatic ss_high();
        @(posedge clk); #2;
        spi_ss = 1'b1;
        if (frame_has_rx) m_frames = m_frames + 8'd1;
        frame_has_rx = 1'b0;
        repeat (4) @(posedge clk);
        #2;
    endtask

    task automatic wait_drain(input string name);
        int t;
        kbd_ready = 1'b1;
        t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL %s_drain: %0d entries still expected after timeout, required 0", name, exp_q.size());
        end
        @(posedge clk); #2;
        vectors++;
        if (kbd_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_empty: kbd_valid=%0b, required 0", name, kbd_valid);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b0; spi_ss = 1'b1; rx_valid = 1'b0; rx_byte = 8'h00;
        kbd_ready = 1'b0; led_state = 8'h00;
        #2;
        vectors++;
        if (all_outs !== 41'h0) begin
            miscompares++;
            $display("FAIL reset_outs: got %h, required 0", all_outs);
        end
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
    endtask

    task automatic test_kbd_basic();
        kbd_ready = 1'b1;
        ss_low();
        send_byte(8'h01); send_byte(8'h03);
        kbd_byte(8'hAA, 1'b0); kbd_byte(8'hBB, 1'b0); kbd_byte(8'hCC, 1'b1);
        ss_high();
        wait_drain("kbd_basic");
        vectors++;
        if ({err_overflow, err_badcmd, frame_count} !== {m_ovf, m_bad, m_frames}) begin
            miscompares++;
            $display("FAIL kbd_basic_flags: got ovf=%0b bad=%0b fc=%0d, required ovf=%0b bad=%0b fc=%0d",
                     err_overflow, err_badcmd, frame_count, m_ovf, m_bad, m_frames);
        end
    endtask

    task automatic test_nop();
        ss_low();
        send_byte(8'h00); send_byte(8'h00);
        ss_high();
        vectors++;
        if ({err_overflow, err_badcmd, frame_count} !== {m_ovf, m_bad, m_frames}) begin
            miscompares++;
            $display("FAIL nop_flags: got ovf=%0b bad=%0b fc=%0d, required ovf=%0b bad=%0b fc=%0d",
                     err_overflow, err_badcmd, frame_count, m_ovf, m_bad, m_frames);
        end
    endtask

    task automatic test_cfgw_good();
        int we0;
        we0 = we_count;
        ss_low();
        send_byte(8'h03); send_byte(8'h05); send_byte(8'h5A);
        ss_high();
        vectors++;
        if ({we_count - we0, we_addr, we_data} !== {32'd1, 4'h5, 8'h5A}) begin
            miscompares++;
            $display("FAIL cfgw_write: got pulses=%0d addr=%h data=%h, required pulses=1 addr=5 data=5a",
                     we_count - we0, we_addr, we_data);
        end
    endtask

    task automatic test_cfgw_trunc();
        int we0;
        we0 = we_count;
        ss_low();
        send_byte(8'h03); send_byte(8'h05);
        ss_high();
        m_bad = 1'b1;
        vectors++;
        if (we_count != we0) begin
            miscompares++;
            $display("FAIL cfgw_trunc_we: got %0d pulses, required 0", we_count - we0);
        end
        vectors++;
        if ({err_overflow, err_badcmd, frame_count} !== {m_ovf, m_bad, m_frames}) begin
            miscompares++;
            $display("FAIL cfgw_trunc_flags: got ovf=%0b bad=%0b fc=%0d, required ovf=%0b bad=%0b fc=%0d",
                     err_overflow, err_badcmd, frame_count, m_ovf, m_bad, m_frames);
        end
    endtask

    task automatic test_overflow();
        kbd_ready = 1'b0;
        for (int f = 0; f < 3; f++) begin
            ss_low();
            send_byte(8'h01); send_byte(8'h06);
            for (int i = 0; i < 6; i++) kbd_byte(8'(16 * f + i + 1), (i == 5));
            ss_high();
        end
        vectors++;
        if ({kbd_valid, err_overflow, frame_count} !== {1'b1, m_ovf, m_frames}) begin
            miscompares++;
            $display("FAIL overflow_flags: got valid=%0b ovf=%0b fc=%0d, required valid=1 ovf=%0b fc=%0d",
                     kbd_valid, err_overflow, frame_count, m_ovf, m_frames);
        end
        wait_drain("overflow");
        kbd_ready = 1'b0;
    endtask

    task automatic test_stat();
        logic [7:0] exp_tx [5];
        int lvl;
        led_state = 8'($urandom);
        lvl = (exp_q.size() > 15) ? 15 : exp_q.size();
        exp_tx[0] = {m_ovf, m_bad, 2'b00, 4'(lvl)};
        exp_tx[1] = led_state;
        exp_tx[2] = VERSION;
        exp_tx[3] = 8'h00;
        exp_tx[4] = 8'h00;
        ss_low();
        for (int i = 0; i < 5; i++) begin
            send_byte((i == 0) ? 8'h02 : 8'h00);
            if (i == 0) begin
                m_ovf = 1'b0;
                m_bad = 1'b0;
            end
            vectors++;
            if (tx_byte !== exp_tx[i]) begin
                miscompares++;
                $display("FAIL stat_tx%0d: got %h, required %h", i, tx_byte, exp_tx[i]);
            end
        end
        ss_high();
        vectors++;
        if ({tx_byte, err_overflow, err_badcmd} !== {8'h00, m_ovf, m_bad}) begin
            miscompares++;
            $display("FAIL stat_after: got tx=%h ovf=%0b bad=%0b, required tx=00 ovf=%0b bad=%0b",
                     tx_byte, err_overflow, err_badcmd, m_ovf, m_bad);
        end
    endtask

    task automatic test_stat_after_overflow();
        kbd_ready = 1'b0;
        ss_low();
        send_byte(8'h01); send_byte(8'h02);
        kbd_byte(8'h11, 1'b0); kbd_byte(8'h22, 1'b1);
        ss_high();
        test_stat();
    endtask

    // FIFO already holds 2 entries with kbd_ready low; fill it, then push while popping.
    task automatic test_full_push_pop();
        ss_low();
        send_byte(8'h01); send_byte(8'h06);
        for (int i = 0; i < 6; i++) kbd_byte(8'hA0 + 8'(i), (i == 5));
        ss_high();
        ss_low();
        send_byte(8'h01); send_byte(8'h01);
        @(posedge clk); #2;
        kbd_ready = 1'b1;
        rx_valid  = 1'b1;
        rx_byte   = 8'h77;
        exp_q.push_back({1'b1, 8'h77});
        frame_has_rx = 1'b1;
        @(posedge clk); #2;
        rx_valid = 1'b0;
        ss_high();
        vectors++;
        if (err_overflow !== m_ovf) begin
            miscompares++;
            $display("FAIL full_push_pop_ovf: got %0b, required %0b", err_overflow, m_ovf);
        end
        wait_drain("full_push_pop");
    endtask

    task automatic test_cfgr();
        ss_low();
        send_byte(8'h04); send_byte(8'h07);
        vectors++;
        if (tx_byte !== 8'h00) begin
            miscompares++;
            $display("FAIL cfgr_early: got %h, required 00", tx_byte);
        end
        @(posedge clk); #2;
        vectors++;
        if ({cfg_addr, tx_byte} !== {4'h7, 8'h3C}) begin
            miscompares++;
            $display("FAIL cfgr_reply: got addr=%h tx=%h, required addr=7 tx=3c", cfg_addr, tx_byte);
        end
        send_byte(8'h00); send_byte(8'h00);
        vectors++;
        if (tx_byte !== 8'h3C) begin
            miscompares++;
            $display("FAIL cfgr_hold: got %h, required 3c", tx_byte);
        end
        ss_high();
        vectors++;
        if (tx_byte !== 8'h00) begin
            miscompares++;
            $display("FAIL cfgr_frame_end: got %h, required 00", tx_byte);
        end
    endtask

    task automatic test_bad_opcode();
        test_stat();
        kbd_ready = 1'b1;
        ss_low();
        send_byte(8'h7E); send_byte(8'h01); send_byte(8'h03); send_byte(8'hAA);
        ss_high();
        m_bad = 1'b1;
        vectors++;
        if ({kbd_valid, err_overflow, err_badcmd, frame_count} !== {1'b0, m_ovf, m_bad, m_frames}) begin
            miscompares++;
            $display("FAIL bad_opcode: got valid=%0b ovf=%0b bad=%0b fc=%0d, required valid=0 ovf=%0b bad=%0b fc=%0d",
                     kbd_valid, err_overflow, err_badcmd, frame_count, m_ovf, m_bad, m_frames);
        end
    endtask

    task automatic test_len_zero();
        test_stat();
        kbd_ready = 1'b1;
        ss_low();
        send_byte(8'h01); send_byte(8'h00); send_byte(8'hAA);
        ss_high();
        m_bad = 1'b1;
        vectors++;
        if ({kbd_valid, err_badcmd, frame_count} !== {1'b0, m_bad, m_frames}) begin
            miscompares++;
            $display("FAIL len_zero: got valid=%0b bad=%0b fc=%0d, required valid=0 bad=%0b fc=%0d",
                     kbd_valid, err_badcmd, frame_count, m_bad, m_frames);
        end
    endtask

    task automatic test_reset_mid();
        kbd_ready = 1'b0;
        ss_low();
        send_byte(8'h01); send_byte(8'h06);
        kbd_byte(8'hD1, 1'b0); kbd_byte(8'hD2, 1'b0);
        vectors++;
        if (kbd_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_mid_pre: kbd_valid=%0b, required 1", kbd_valid);
        end
        #1 reset = 1'b0;
        #1;
        vectors++;
        if (all_outs !== 41'h0) begin
            miscompares++;
            $display("FAIL reset_mid_async: got %h, required 0", all_outs);
        end
        exp_q.delete();
        m_ovf = 1'b0; m_bad = 1'b0; m_frames = 8'h00; frame_has_rx = 1'b0;
        @(posedge clk); #2;
        reset = 1'b1;
        ss_high();
        vectors++;
        if (all_outs !== 41'h0) begin
            miscompares++;
            $display("FAIL reset_mid_after: got %h, required 0", all_outs);
        end
    endtask

    initial begin
        test_reset();
        test_kbd_basic();
        test_nop();
        test_cfgw_good();
        test_overflow();
        test_stat_after_overflow();
        test_full_push_pop();
        test_cfgw_trunc();
        test_cfgr();
        test_bad_opcode();
        test_len_zero();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
